// File: rtl/dig_code_scan.sv
// Multi-channel digit-to-code mapper with shadow registers, a clock-divided
// channel scanner (or channel hold), and fully registered outputs.
module dig_code_scan #(
  parameter  int CHANNELS = 4,
  parameter  int IN_W     = 4,
  parameter  int OUT_W    = 8,
  parameter  int MAX_CODE = 8,
  parameter  int SCAN_DIV = 50000,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [CHANNELS*IN_W-1:0] iDIG,
  input  logic                     iLOAD,
  input  logic                     iMODE,
  input  logic [CH_W-1:0]          iCH,
  output logic [OUT_W-1:0]         oHEX_D,
  output logic [CHANNELS-1:0]      oSEL,
  output logic                     oFRAME
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [IN_W-1:0]  r_shadow [CHANNELS];
  logic [DIV_W-1:0] r_div_cnt;
  logic [CH_W-1:0]  r_ch_idx;

  logic [CH_W-1:0]     w_ch_sel;
  logic                w_step;
  logic                w_wrap;
  logic [OUT_W-1:0]    w_code;
  logic [CHANNELS-1:0] w_onehot;

  // Codes 1..MAX_CODE pass through; 0 and anything above MAX_CODE saturate.
  function automatic logic [OUT_W-1:0] map_code(input logic [IN_W-1:0] v);
    if (v == '0 || int'(v) > MAX_CODE) return OUT_W'(MAX_CODE);
    return OUT_W'(v);
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_ch_sel = r_ch_idx;
    if (iMODE) begin
      w_ch_sel = (int'(iCH) > CHANNELS - 1) ? CH_W'(CHANNELS - 1) : iCH;
    end
  end

  assign w_step   = !iMODE && (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_wrap   = w_step && (r_ch_idx == CH_W'(CHANNELS - 1));
  assign w_code   = map_code(r_shadow[w_ch_sel]);
  assign w_onehot = CHANNELS'(1) << w_ch_sel;

  // NOTE: the shadow array is small and drives the outputs right after reset,
  // so it is cleared by the async reset like any other register (not left as
  // an unreset RAM).
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int k = 0; k < CHANNELS; k++) r_shadow[k] <= '0;
    end else if (iLOAD) begin
      for (int k = 0; k < CHANNELS; k++) r_shadow[k] <= iDIG[k*IN_W +: IN_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_div_cnt <= '0;
      r_ch_idx  <= '0;
    end else if (!iMODE) begin
      if (w_step) begin
        r_div_cnt <= '0;
        r_ch_idx  <= w_wrap ? '0 : r_ch_idx + CH_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Outputs reflect the channel selected before this edge: one clock latency.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oHEX_D <= '0;
      oSEL   <= '0;
      oFRAME <= 1'b0;
    end else begin
      oHEX_D <= w_code;
      oSEL   <= w_onehot;
      oFRAME <= w_wrap;
    end
  end

endmodule

// File: tb/tb_dig_code_scan.sv
// Directed bench for dig_code_scan with CHANNELS=4, IN_W=4, OUT_W=8,
// MAX_CODE=8, SCAN_DIV=4: mapping table in hold mode plus scan/reset sequences.
module tb_dig_code_scan;

  localparam int CHANNELS = 4;
  localparam int IN_W     = 4;
  localparam int OUT_W    = 8;
  localparam int MAX_CODE = 8;
  localparam int SCAN_DIV = 4;
  localparam int CH_W     = 2;

  logic                     iCLK = 1'b0;
  logic                     iRST;
  logic [CHANNELS*IN_W-1:0] iDIG;
  logic                     iLOAD;
  logic                     iMODE;
  logic [CH_W-1:0]          iCH;
  logic [OUT_W-1:0]         oHEX_D;
  logic [CHANNELS-1:0]      oSEL;
  logic                     oFRAME;

  dig_code_scan #(
    .CHANNELS(CHANNELS), .IN_W(IN_W), .OUT_W(OUT_W),
    .MAX_CODE(MAX_CODE), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDIG(iDIG), .iLOAD(iLOAD), .iMODE(iMODE),
    .iCH(iCH), .oHEX_D(oHEX_D), .oSEL(oSEL), .oFRAME(oFRAME)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [15:0] dig;
    logic [1:0]  ch;
    int          exp_hex;
    int          exp_sel;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int scan_n   = 0;  // scan-mode edges since reset release
  int exp_code [CHANNELS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  function automatic int onehot(input int ch);
    return 1 << ch;
  endfunction

  // Channel presented after the n-th scan edge: ch_idx just before that edge.
  function automatic int scan_ch(input int n);
    return ((n - 1) / SCAN_DIV) % CHANNELS;
  endfunction

  task automatic scan_steps(input int count);
    for (int i = 0; i < count; i++) begin
      step();
      scan_n++;
      check("scan_hex", oHEX_D, exp_code[scan_ch(scan_n)]);
      check("scan_sel", oSEL, onehot(scan_ch(scan_n)));
      check("scan_frame", oFRAME, (scan_n % (SCAN_DIV * CHANNELS) == 0) ? 1 : 0);
    end
  endtask

  task automatic hold_steps(input int count, input int hex, input int sel);
    for (int i = 0; i < count; i++) begin
      step();
      check("hold_hex", oHEX_D, hex);
      check("hold_sel", oSEL, sel);
      check("hold_frame", oFRAME, 0);
    end
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{16'h0000, 2'd0, 8, 4'b0001};  // zero saturates
    vecs[1] = '{16'h0001, 2'd0, 1, 4'b0001};  // lower bound
    vecs[2] = '{16'h0070, 2'd1, 7, 4'b0010};
    vecs[3] = '{16'h0800, 2'd2, 8, 4'b0100};  // exactly MAX_CODE
    vecs[4] = '{16'h9000, 2'd3, 8, 4'b1000};  // MAX_CODE+1 saturates
    vecs[5] = '{16'hF000, 2'd3, 8, 4'b1000};  // all ones saturates
    vecs[6] = '{16'h3000, 2'd3, 3, 4'b1000};
    vecs[7] = '{16'h0020, 2'd1, 2, 4'b0010};
    vecs[8] = '{16'h0400, 2'd2, 4, 4'b0100};
    vecs[9] = '{16'h1234, 2'd0, 4, 4'b0001};

    iRST = 1'b1; iDIG = '0; iLOAD = 1'b0; iMODE = 1'b0; iCH = '0;
    for (int k = 0; k < CHANNELS; k++) exp_code[k] = MAX_CODE;

    step();
    check("rst_hex", oHEX_D, 0);
    check("rst_sel", oSEL, 0);
    check("rst_frame", oFRAME, 0);
    iRST = 1'b0;

    // Unloaded scan: every channel saturates, 4 clocks per channel, frame every 16.
    scan_steps(32);

    // Load ch3=9, ch2=5, ch1=1, ch0=0 and keep scanning.
    iDIG = 16'h9510; iLOAD = 1'b1;
    exp_code[0] = 8; exp_code[1] = 1; exp_code[2] = 5; exp_code[3] = 8;
    scan_steps(1);
    iLOAD = 1'b0;
    scan_steps(21);  // stop mid-dwell on ch1 (div_cnt=2)

    // Hold channel 2, then 3; counters must stay frozen.
    iMODE = 1'b1; iCH = 2'd2;
    hold_steps(50, 5, 4'b0100);
    iCH = 2'd3;
    hold_steps(3, 8, 4'b1000);

    // Resume: same channel, same count; then load on the ch1->ch2 step.
    iMODE = 1'b0;
    scan_steps(1);
    iDIG = 16'h9710; iLOAD = 1'b1; exp_code[2] = 7;
    scan_steps(1);
    iLOAD = 1'b0;
    scan_steps(8);

    // Mapping table, applied in hold mode: 2 edges from load to output.
    iMODE = 1'b1;
    for (int v = 0; v < 10; v++) begin
      iDIG = vecs[v].dig; iCH = vecs[v].ch; iLOAD = 1'b1;
      step();
      iLOAD = 1'b0;
      step();
      check($sformatf("vec%0d_hex", v), oHEX_D, vecs[v].exp_hex);
      check($sformatf("vec%0d_sel", v), oSEL, vecs[v].exp_sel);
      check($sformatf("vec%0d_frame", v), oFRAME, 0);
    end

    // Shadow now holds 1,2,3,4 (ch3..ch0); scan to mid-dwell on ch2.
    iMODE = 1'b0;
    exp_code[0] = 4; exp_code[1] = 3; exp_code[2] = 2; exp_code[3] = 1;
    scan_steps(10);
    check("pre_rst_sel", oSEL, 4'b0100);

    // Asynchronous reset between edges clears outputs immediately.
    #2 iRST = 1'b1;
    #1;
    check("async_hex", oHEX_D, 0);
    check("async_sel", oSEL, 0);
    check("async_frame", oFRAME, 0);
    step();
    iRST = 1'b0;
    scan_n = 0;
    for (int k = 0; k < CHANNELS; k++) exp_code[k] = MAX_CODE;
    scan_steps(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
